// File: rtl/decode_pkg.sv
// Shared encodings for the SPARC V9 decode slice: register classes, micro-op
// types, functional-unit classes, branch kinds, flag bit positions and the
// packed decode record passed from the combinational decoder to the register
// stage.
package decode_pkg;

  typedef enum logic [3:0] {
    RT_NONE = 4'd0,
    RT_INT  = 4'd1,
    RT_CC   = 4'd3
  } reg_type_e;

  typedef enum logic [2:0] {
    MT_EXEC    = 3'd0,
    MT_CONTROL = 3'd1,
    MT_LOAD    = 3'd2,
    MT_STORE   = 3'd3,
    MT_INVALID = 3'd7
  } m_type_e;

  typedef enum logic [3:0] {
    FU_NONE   = 4'd0,
    FU_INTALU = 4'd1,
    FU_BRANCH = 4'd2,
    FU_RDPORT = 4'd3,
    FU_WRPORT = 4'd4
  } futype_e;

  typedef enum logic [3:0] {
    BR_NONE   = 4'd0,
    BR_COND   = 4'd1,
    BR_UNCOND = 4'd2,
    BR_CALL   = 4'd3
  } branch_type_e;

  localparam int unsigned FLAG_ANNUL   = 0;
  localparam int unsigned FLAG_PREDICT = 1;
  localparam int unsigned FLAG_SIGNED  = 2;
  localparam int unsigned FLAG_SETCC   = 3;
  localparam int unsigned FLAG_IMM     = 4;
  localparam int unsigned FLAG_X       = 5;

  localparam logic [8:0] OPC_INVALID = 9'h1FF;
  localparam logic [8:0] OPC_CALL    = 9'h040;

  typedef struct packed {
    logic [5:0] num;
    reg_type_e  rtype;
    logic       valid;
  } operand_t;

  typedef struct packed {
    operand_t     rd;
    operand_t     rd2;
    operand_t     rs1;
    operand_t     rs2;
    operand_t     rs3;
    operand_t     rs4;
    m_type_e      m_type;
    futype_e      futype;
    logic [8:0]   opcode;
    branch_type_e branch_type;
    logic [63:0]  imm;
    logic [7:0]   ccshift;
    logic [7:0]   access_size;
    logic [7:0]   flags;
    logic         fail;
  } decode_t;

  function automatic operand_t mk_op(input logic [4:0] n, input reg_type_e t);
    operand_t o;
    o.num   = {1'b0, n};
    o.rtype = t;
    o.valid = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational field decode of one SPARC V9 instruction word.
// Ports:
//   instr_i  32-bit instruction word
//   dec_o    full decode record (operands, class, opcode, immediate, flags)
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output decode_t     dec_o
);

  logic [1:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic        i_bit, x_bit;
  logic [3:0]  cond;
  logic [63:0] simm13, shcnt;
  logic        is_shift, alu_ok, is_load, is_store, uses_rs;

  assign op    = instr_i[31:30];
  assign rd    = instr_i[29:25];
  assign op2   = instr_i[24:22];
  assign op3   = instr_i[24:19];
  assign rs1   = instr_i[18:14];
  assign i_bit = instr_i[13];
  assign x_bit = instr_i[12];
  assign rs2   = instr_i[4:0];
  assign cond  = instr_i[28:25];

  assign simm13 = {{51{instr_i[12]}}, instr_i[12:0]};
  assign shcnt  = x_bit ? {58'b0, instr_i[5:0]} : {59'b0, instr_i[4:0]};

  assign is_shift = op3 inside {6'h25, 6'h26, 6'h27};
  // 0x00-0x1E minus 0x0F and the 0x?9/0x?D holes, plus the shifts
  assign alu_ok   = ((op3 <= 6'h1E) && (op3 != 6'h0F) &&
                     (op3[3:0] != 4'h9) && (op3[3:0] != 4'hD)) || is_shift;
  assign is_load  = op3 inside {[6'h00:6'h03], [6'h08:6'h0B]};
  assign is_store = op3 inside {[6'h04:6'h07], 6'h0E};
  assign uses_rs  = ((op == 2'b10) && alu_ok) ||
                    ((op == 2'b11) && (is_load || is_store));

  always_comb begin
    dec_o = '0;
    case (op)
      2'b00: begin
        dec_o.opcode = {6'b0, op2};
        case (op2)
          3'd4: begin
            dec_o.rd     = mk_op(rd, RT_INT);
            dec_o.imm    = {32'b0, instr_i[21:0], 10'b0};
            dec_o.m_type = MT_EXEC;
            dec_o.futype = FU_INTALU;
          end
          3'd1, 3'd2: begin
            dec_o.m_type      = MT_CONTROL;
            dec_o.futype      = FU_BRANCH;
            dec_o.rs1         = mk_op(5'd0, RT_CC);
            // ba (8) and bn (0) differ only in cond[3]
            dec_o.branch_type = (cond[2:0] == 3'd0) ? BR_UNCOND : BR_COND;
            dec_o.flags[FLAG_ANNUL] = instr_i[29];
            if (op2 == 3'd1) begin
              dec_o.imm     = {{43{instr_i[18]}}, instr_i[18:0], 2'b00};
              dec_o.ccshift = instr_i[21] ? 8'd4 : 8'd0;
              dec_o.flags[FLAG_PREDICT] = instr_i[19];
            end else begin
              dec_o.imm = {{40{instr_i[21]}}, instr_i[21:0], 2'b00};
            end
          end
          default: dec_o.fail = 1'b1;
        endcase
      end
      2'b01: begin
        dec_o.opcode      = OPC_CALL;
        dec_o.m_type      = MT_CONTROL;
        dec_o.futype      = FU_BRANCH;
        dec_o.branch_type = BR_CALL;
        dec_o.imm         = {{32{instr_i[29]}}, instr_i[29:0], 2'b00};
        dec_o.rd          = mk_op(5'd15, RT_INT);
      end
      2'b10: begin
        if (alu_ok) begin
          dec_o.opcode = {1'b0, op, op3};
          dec_o.m_type = MT_EXEC;
          dec_o.futype = FU_INTALU;
          dec_o.rd     = mk_op(rd, RT_INT);
          if (op3[4]) begin
            dec_o.rd2 = mk_op(5'd0, RT_CC);
            dec_o.flags[FLAG_SETCC] = 1'b1;
          end
          if (is_shift) dec_o.flags[FLAG_X] = x_bit;
        end else begin
          dec_o.fail = 1'b1;
        end
      end
      default: begin
        if (is_load || is_store) begin
          dec_o.opcode = {1'b0, op, op3};
          if (is_load) begin
            dec_o.m_type = MT_LOAD;
            dec_o.futype = FU_RDPORT;
            dec_o.rd     = mk_op(rd, RT_INT);
            dec_o.flags[FLAG_SIGNED] = op3[3];
          end else begin
            dec_o.m_type = MT_STORE;
            dec_o.futype = FU_WRPORT;
            dec_o.rs3    = mk_op(rd, RT_INT);
          end
          case (op3[1:0])
            2'b00:   dec_o.access_size = 8'd4;
            2'b01:   dec_o.access_size = 8'd1;
            2'b10:   dec_o.access_size = 8'd2;
            default: dec_o.access_size = 8'd8;
          endcase
          if (op3 == 6'h0E) dec_o.access_size = 8'd8;
        end else begin
          dec_o.fail = 1'b1;
        end
      end
    endcase

    // ALU and load/store share the rs1 + (rs2 | simm13/shcnt) source form
    if (uses_rs) begin
      dec_o.rs1 = mk_op(rs1, RT_INT);
      if (i_bit) begin
        dec_o.imm = ((op == 2'b10) && is_shift) ? shcnt : simm13;
        dec_o.flags[FLAG_IMM] = 1'b1;
      end else begin
        dec_o.rs2 = mk_op(rs2, RT_INT);
      end
    end

    if (dec_o.fail) begin
      dec_o        = '0;
      dec_o.fail   = 1'b1;
      dec_o.m_type = MT_INVALID;
      dec_o.opcode = OPC_INVALID;
    end
  end

endmodule

// File: rtl/sparc_decode_unit.sv
// Registered SPARC V9 instruction decoder: one instruction per cycle, outputs
// valid one rclk edge after the instruction is presented.
// Ports:
//   rclk, reset (sync, active-low), instruction[31:0]
//   o_<opnd>, o_<opnd>_type, o_<opnd>_valid for rd, rd2, rs1..rs4
//   o_m_type, o_m_futype, o_m_opcode, o_m_branch_type, o_m_imm,
//   o_m_ccshift, o_m_access_size, o_m_flags, o_fail
module sparc_decode_unit
  import decode_pkg::*;
(
  input  logic        rclk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [5:0]  o_rd,
  output logic [3:0]  o_rd_type,
  output logic        o_rd_valid,
  output logic [5:0]  o_rd2,
  output logic [3:0]  o_rd2_type,
  output logic        o_rd2_valid,
  output logic [5:0]  o_rs1,
  output logic [3:0]  o_rs1_type,
  output logic        o_rs1_valid,
  output logic [5:0]  o_rs2,
  output logic [3:0]  o_rs2_type,
  output logic        o_rs2_valid,
  output logic [5:0]  o_rs3,
  output logic [3:0]  o_rs3_type,
  output logic        o_rs3_valid,
  output logic [5:0]  o_rs4,
  output logic [3:0]  o_rs4_type,
  output logic        o_rs4_valid,
  output logic [2:0]  o_m_type,
  output logic [3:0]  o_m_futype,
  output logic [8:0]  o_m_opcode,
  output logic [3:0]  o_m_branch_type,
  output logic [63:0] o_m_imm,
  output logic [7:0]  o_m_ccshift,
  output logic [7:0]  o_m_access_size,
  output logic [7:0]  o_m_flags,
  output logic        o_fail
);

  decode_t dec_d, dec_q;

  decode_comb u_decode_comb (
    .instr_i (instruction),
    .dec_o   (dec_d)
  );

  always_ff @(posedge rclk) begin
    if (!reset) dec_q <= '0;
    else        dec_q <= dec_d;
  end

  assign o_rd            = dec_q.rd.num;
  assign o_rd_type       = dec_q.rd.rtype;
  assign o_rd_valid      = dec_q.rd.valid;
  assign o_rd2           = dec_q.rd2.num;
  assign o_rd2_type      = dec_q.rd2.rtype;
  assign o_rd2_valid     = dec_q.rd2.valid;
  assign o_rs1           = dec_q.rs1.num;
  assign o_rs1_type      = dec_q.rs1.rtype;
  assign o_rs1_valid     = dec_q.rs1.valid;
  assign o_rs2           = dec_q.rs2.num;
  assign o_rs2_type      = dec_q.rs2.rtype;
  assign o_rs2_valid     = dec_q.rs2.valid;
  assign o_rs3           = dec_q.rs3.num;
  assign o_rs3_type      = dec_q.rs3.rtype;
  assign o_rs3_valid     = dec_q.rs3.valid;
  assign o_rs4           = dec_q.rs4.num;
  assign o_rs4_type      = dec_q.rs4.rtype;
  assign o_rs4_valid     = dec_q.rs4.valid;
  assign o_m_type        = dec_q.m_type;
  assign o_m_futype      = dec_q.futype;
  assign o_m_opcode      = dec_q.opcode;
  assign o_m_branch_type = dec_q.branch_type;
  assign o_m_imm         = dec_q.imm;
  assign o_m_ccshift     = dec_q.ccshift;
  assign o_m_access_size = dec_q.access_size;
  assign o_m_flags       = dec_q.flags;
  assign o_fail          = dec_q.fail;

endmodule

// File: tb/tb_sparc_decode_unit.sv
// Directed bench for sparc_decode_unit with hand-computed expected decodes.
module tb_sparc_decode_unit;

  logic        rclk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = '0;
  logic [5:0]  o_rd, o_rd2, o_rs1, o_rs2, o_rs3, o_rs4;
  logic [3:0]  o_rd_type, o_rd2_type, o_rs1_type, o_rs2_type, o_rs3_type, o_rs4_type;
  logic        o_rd_valid, o_rd2_valid, o_rs1_valid, o_rs2_valid, o_rs3_valid, o_rs4_valid;
  logic [2:0]  o_m_type;
  logic [3:0]  o_m_futype, o_m_branch_type;
  logic [8:0]  o_m_opcode;
  logic [63:0] o_m_imm;
  logic [7:0]  o_m_ccshift, o_m_access_size, o_m_flags;
  logic        o_fail;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 rclk = ~rclk;

  sparc_decode_unit dut (
    .rclk(rclk), .reset(reset), .instruction(instruction),
    .o_rd(o_rd), .o_rd_type(o_rd_type), .o_rd_valid(o_rd_valid),
    .o_rd2(o_rd2), .o_rd2_type(o_rd2_type), .o_rd2_valid(o_rd2_valid),
    .o_rs1(o_rs1), .o_rs1_type(o_rs1_type), .o_rs1_valid(o_rs1_valid),
    .o_rs2(o_rs2), .o_rs2_type(o_rs2_type), .o_rs2_valid(o_rs2_valid),
    .o_rs3(o_rs3), .o_rs3_type(o_rs3_type), .o_rs3_valid(o_rs3_valid),
    .o_rs4(o_rs4), .o_rs4_type(o_rs4_type), .o_rs4_valid(o_rs4_valid),
    .o_m_type(o_m_type), .o_m_futype(o_m_futype), .o_m_opcode(o_m_opcode),
    .o_m_branch_type(o_m_branch_type), .o_m_imm(o_m_imm),
    .o_m_ccshift(o_m_ccshift), .o_m_access_size(o_m_access_size),
    .o_m_flags(o_m_flags), .o_fail(o_fail)
  );

  // Operand descriptor {num, type, valid}
  localparam logic [10:0] NONE = 11'h0;
  function automatic logic [10:0] OI(input int unsigned n);
    return {n[5:0], 4'd1, 1'b1};
  endfunction
  function automatic logic [10:0] OC(input int unsigned n);
    return {n[5:0], 4'd3, 1'b1};
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic rst_n, input logic [31:0] w);
    @(negedge rclk);
    reset = rst_n;
    instruction = w;
    @(posedge rclk);
    #1;
    n_vec++;
  endtask

  task automatic expect_dec(input string tag,
      input logic [10:0] rd, input logic [10:0] rd2, input logic [10:0] rs1,
      input logic [10:0] rs2, input logic [10:0] rs3, input logic [10:0] rs4,
      input logic [2:0] mt, input logic [3:0] fu, input logic [8:0] opc,
      input logic [3:0] bt, input logic [63:0] imm, input logic [7:0] ccs,
      input logic [7:0] asz, input logic [7:0] flg, input logic fail);
    cmp({tag, ".rd"},    {53'b0, o_rd,  o_rd_type,  o_rd_valid},  {53'b0, rd});
    cmp({tag, ".rd2"},   {53'b0, o_rd2, o_rd2_type, o_rd2_valid}, {53'b0, rd2});
    cmp({tag, ".rs1"},   {53'b0, o_rs1, o_rs1_type, o_rs1_valid}, {53'b0, rs1});
    cmp({tag, ".rs2"},   {53'b0, o_rs2, o_rs2_type, o_rs2_valid}, {53'b0, rs2});
    cmp({tag, ".rs3"},   {53'b0, o_rs3, o_rs3_type, o_rs3_valid}, {53'b0, rs3});
    cmp({tag, ".rs4"},   {53'b0, o_rs4, o_rs4_type, o_rs4_valid}, {53'b0, rs4});
    cmp({tag, ".mtype"}, {61'b0, o_m_type},        {61'b0, mt});
    cmp({tag, ".fu"},    {60'b0, o_m_futype},      {60'b0, fu});
    cmp({tag, ".opc"},   {55'b0, o_m_opcode},      {55'b0, opc});
    cmp({tag, ".br"},    {60'b0, o_m_branch_type}, {60'b0, bt});
    cmp({tag, ".imm"},   o_m_imm, imm);
    cmp({tag, ".ccs"},   {56'b0, o_m_ccshift},     {56'b0, ccs});
    cmp({tag, ".asz"},   {56'b0, o_m_access_size}, {56'b0, asz});
    cmp({tag, ".flags"}, {56'b0, o_m_flags},       {56'b0, flg});
    cmp({tag, ".fail"},  {63'b0, o_fail},          {63'b0, fail});
  endtask

  initial begin
    // Reset held with a legal instruction present: reset must win.
    apply(1'b0, 32'h86102001);
    expect_dec("reset", NONE, NONE, NONE, NONE, NONE, NONE,
               3'd0, 4'd0, 9'h000, 4'd0, 64'h0, 8'h0, 8'h0, 8'h00, 1'b0);

    // Back-to-back decodes, one per cycle.
    apply(1'b1, 32'h86102001);  // or %g0,1,%g3
    expect_dec("or_imm", OI(3), NONE, OI(0), NONE, NONE, NONE,
               3'd0, 4'd1, 9'h082, 4'd0, 64'h1, 8'h0, 8'h0, 8'h10, 1'b0);
    apply(1'b1, 32'hB4102001);  // same, rd=26
    expect_dec("or_rd26", OI(26), NONE, OI(0), NONE, NONE, NONE,
               3'd0, 4'd1, 9'h082, 4'd0, 64'h1, 8'h0, 8'h0, 8'h10, 1'b0);
    apply(1'b1, 32'h808B0008);  // andcc %o4,%o0,%g0
    expect_dec("andcc", OI(0), OC(0), OI(12), OI(8), NONE, NONE,
               3'd0, 4'd1, 9'h091, 4'd0, 64'h0, 8'h0, 8'h0, 8'h08, 1'b0);
    apply(1'b1, 32'h05000006);  // sethi 6,%g2
    expect_dec("sethi", OI(2), NONE, NONE, NONE, NONE, NONE,
               3'd0, 4'd1, 9'h004, 4'd0, 64'h1800, 8'h0, 8'h0, 8'h00, 1'b0);
    apply(1'b1, 32'h9928C00B);  // sll %g3,%o3,%o4
    expect_dec("sll_reg", OI(12), NONE, OI(3), OI(11), NONE, NONE,
               3'd0, 4'd1, 9'h0A5, 4'd0, 64'h0, 8'h0, 8'h0, 8'h00, 1'b0);
    apply(1'b1, 32'h89297FFF);  // sllx %g5,63,%g4 (x=1, bits[11:6] set)
    expect_dec("sllx_imm", OI(4), NONE, OI(5), NONE, NONE, NONE,
               3'd0, 4'd1, 9'h0A5, 4'd0, 64'h3F, 8'h0, 8'h0, 8'h30, 1'b0);
    apply(1'b1, 32'h89296FFF);  // sll %g5,31,%g4 (x=0 masks to 5 bits)
    expect_dec("sll_imm", OI(4), NONE, OI(5), NONE, NONE, NONE,
               3'd0, 4'd1, 9'h0A5, 4'd0, 64'h1F, 8'h0, 8'h0, 8'h10, 1'b0);
    apply(1'b1, 32'h1240004F);  // BPcc cond 9, disp19 0x4F
    expect_dec("bpcc_cond", NONE, NONE, OC(0), NONE, NONE, NONE,
               3'd1, 4'd2, 9'h001, 4'd1, 64'h13C, 8'h0, 8'h0, 8'h00, 1'b0);
    apply(1'b1, 32'h00680001);  // BPcc bn, cc1=1, p=1, disp19=1
    expect_dec("bpcc_bn", NONE, NONE, OC(0), NONE, NONE, NONE,
               3'd1, 4'd2, 9'h001, 4'd2, 64'h4, 8'h4, 8'h0, 8'h02, 1'b0);
    apply(1'b1, 32'h30BFFFFF);  // ba,a with disp22=-1
    expect_dec("bicc_ba", NONE, NONE, OC(0), NONE, NONE, NONE,
               3'd1, 4'd2, 9'h002, 4'd2, 64'hFFFF_FFFF_FFFF_FFFC, 8'h0, 8'h0, 8'h01, 1'b0);
    apply(1'b1, 32'h7FFFFFFF);  // call with disp30=-1
    expect_dec("call", OI(15), NONE, NONE, NONE, NONE, NONE,
               3'd1, 4'd2, 9'h040, 4'd3, 64'hFFFF_FFFF_FFFF_FFFC, 8'h0, 8'h0, 8'h00, 1'b0);
    apply(1'b1, 32'hCA487FFF);  // ldsb [%g1-1],%g5
    expect_dec("ldsb", OI(5), NONE, OI(1), NONE, NONE, NONE,
               3'd2, 4'd3, 9'h0C9, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0, 8'h1, 8'h14, 1'b0);
    apply(1'b1, 32'hCE708003);  // stx %g7,[%g2+%g3]
    expect_dec("stx", NONE, NONE, OI(2), OI(3), OI(7), NONE,
               3'd3, 4'd4, 9'h0CE, 4'd0, 64'h0, 8'h0, 8'h8, 8'h00, 1'b0);
    apply(1'b1, 32'h81D80000);  // flush: unsupported
    expect_dec("flush", NONE, NONE, NONE, NONE, NONE, NONE,
               3'd7, 4'd0, 9'h1FF, 4'd0, 64'h0, 8'h0, 8'h0, 8'h00, 1'b1);
    apply(1'b1, 32'h80480000);  // op3 0x09 hole in ALU range
    expect_dec("alu_hole", NONE, NONE, NONE, NONE, NONE, NONE,
               3'd7, 4'd0, 9'h1FF, 4'd0, 64'h0, 8'h0, 8'h0, 8'h00, 1'b1);
    apply(1'b1, 32'h00000000);  // illtrap (op2=0)
    expect_dec("illtrap", NONE, NONE, NONE, NONE, NONE, NONE,
               3'd7, 4'd0, 9'h1FF, 4'd0, 64'h0, 8'h0, 8'h0, 8'h00, 1'b1);

    // Reset mid-stream clears o_fail too, then decode resumes.
    apply(1'b0, 32'h81D80000);
    expect_dec("reset2", NONE, NONE, NONE, NONE, NONE, NONE,
               3'd0, 4'd0, 9'h000, 4'd0, 64'h0, 8'h0, 8'h0, 8'h00, 1'b0);
    apply(1'b1, 32'hB4102001);
    expect_dec("after_rst", OI(26), NONE, OI(0), NONE, NONE, NONE,
               3'd0, 4'd1, 9'h082, 4'd0, 64'h1, 8'h0, 8'h0, 8'h10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sparc_decode_unit.md
# sparc_decode_unit

Registered SPARC V9 instruction decoder for the front end of the timing core. Each cycle it takes one fetched 32-bit instruction and produces register source/destination descriptors, functional-unit class, an internal opcode, a 64-bit immediate and control flags for rename and dispatch. The supported subset is:

- integer ALU and shift operations;
- SETHI, CALL, Bicc and BPcc;
- integer loads and stores.

Every other encoding raises `o_fail`.

## Interface
- No parameters. Shared encodings live in the package.
- One clock; reset is synchronous and active-low.
- `rclk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-low.
- `instruction` in 32: fetched instruction word.
- `o_rd`/`o_rd2`/`o_rs1`/`o_rs2`/`o_rs3`/`o_rs4` out 6 each: architectural register number, zero-extended.
- `o_*_type` out 4 per operand: register class. Encodings: 0 none, 1 int, 3 cc.
- `o_*_valid` out 1 per operand: operand is used.
- `o_m_type` out 3: 0 exec, 1 control, 2 load, 3 store, 7 invalid.
- `o_m_futype` out 4: 0 none, 1 intalu, 2 branch, 3 rdport, 4 wrport.
- `o_m_opcode` out 9: internal opcode.
- `o_m_branch_type` out 4: 0 none, 1 conditional, 2 unconditional (ba/bn), 3 call.
- `o_m_imm` out 64: decoded immediate.
- `o_m_ccshift` out 8: condition-code select.
- `o_m_access_size` out 8: memory access bytes.
- `o_m_flags` out 8: decode flags.
- `o_fail` out 1: unsupported encoding.

## Operation
- **Field extraction.** op=[31:30], rd=[29:25], op2=[24:22], op3=[24:19], rs1=[18:14], i=[13], x=[12], rs2=[4:0].
- **Opcode format.**
  - op=2 or 3: `o_m_opcode`={1'b0, op, op3}.
  - op=0: {1'b0, 2'b00, 3'b000, op2}.
  - CALL: 0x040.
  - Invalid: 0x1FF.
- **ALU (op=2).** Covers op3 0x00–0x0E, 0x10–0x1E (excluding 0x09/0x0D/0x19/0x1D) and shifts 0x25–0x27.
  - m_type exec, futype intalu.
  - rd int valid; rs1 int valid; rs2 int valid when i=0.
  - i=1: imm = sign-extended simm13. Shifts use shcnt zero-extended, [5:0] if x=1 else [4:0].
  - op3[4]=1 (cc-setting): rd2 = 0, type cc, valid.
- **SETHI (op=0, op2=4).** rd int valid, imm = {imm22, 10'b0} zero-extended, exec/intalu.
- **Bicc (op2=2) and BPcc (op2=1).** Control/branch.
  - rs1 = 0, type cc, valid.
  - imm = sign-extended disp22/disp19 << 2.
  - cond in [28:25]: 8 or 0 gives branch_type unconditional, otherwise conditional.
  - BPcc: ccshift = 4 if cc1=[21] is 1, else 0.
- **CALL (op=1).** Control/branch, type call, imm = sign-extended disp30 << 2, rd = 15 int valid.
- **Loads (op=3).** op3 0x00–0x03, 0x08–0x0B: m_type load, futype rdport, rd int valid.
- **Stores (op=3).** op3 0x04–0x07, 0x0E: m_type store, futype wrport, rs3 = rd int valid.
- **Load/store common.** rs1/rs2/imm as for ALU. access_size 1/2/4/8 by op3[1:0] (0x0B/0x0E → 8; 0x03/0x07 doubleword → 8).
- **Flags.**
  - bit0: annul (a).
  - bit1: predict (p, BPcc only).
  - bit2: signed load.
  - bit3: sets cc.
  - bit4: immediate form.
  - bit5: x.
  - bits7:6 are 0.
- **Defaults.** Unused operands are number 0, type 0, valid 0; unused scalar outputs are 0.
- **Unsupported encodings.** `o_fail`=1, m_type 7, opcode 0x1FF, all valids 0, everything else 0.
- `o_rs4` is always invalid in this subset.

## Timing
- One-cycle latency: `instruction` is sampled on rising `rclk`, and all outputs reflect it from that edge until the next.
- `reset`=0 at an edge clears every output to 0, including `o_fail`. This takes priority over decode.
- There is no handshake; a new instruction is accepted every cycle.

## Structure
- Package `decode_pkg` holds:
  - register-type, m_type, futype and branch-type encodings;
  - flag bit indices;
  - the invalid-opcode constant.
- One natural sub-module, `decode_comb`: purely combinational field decode. The top-level only registers its outputs.

## Test plan
- 0x86102001 → rd=3 int valid; rs1=0 valid; rs2 invalid; imm=1; opcode 0x082; flags 0x10; fail 0. 0xB4102001 gives the same except rd=26.
- 0x808B0008 → rd=0 valid; rd2 cc valid; rs1=12; rs2=8; opcode 0x091; flags 0x08; imm 0.
- 0x05000006 → rd=2; imm=0x1800; opcode 0x004; all sources invalid; exec/intalu.
- 0x9928C00B → rd=12; rs1=3; rs2=11; opcode 0x0A5; futype 1; imm 0.
- 0x1240004F → m_type control; branch_type conditional; rs1 cc valid; imm=0x13C; ccshift 0; flags 0; opcode 0x001.
- Check all of the following:
  - `reset`=0 for one edge → every output 0.
  - 0x81D80000 (flush) → fail=1, opcode 0x1FF, all valids 0.
  - Back-to-back vectors update every cycle.
